fifo_param: RTL
===============

Name: fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the 6-bit lane FIFO.
- Generalises data width and depth.
- Adds an occupancy counter and runtime-programmable almost-empty/almost-full thresholds.
- Sits between the lane producer and consumer; Pausa back-pressures the producer before overflow.
- Storage is a separate dual-port RAM; this block owns the pointers, flags, error and read-valid logic.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 2, address bits; DEPTH = 2**ADDR_WIDTH entries (default 4)

Ports:
clk  in  1  single clock; all logic on posedge
reset_L  in  1  synchronous, active-low reset
push  in  1  write request
pop  in  1  read request
Fifo_Data_in  in  DATA_WIDTH  write data, sampled with push
AE_thr  in  ADDR_WIDTH+1  almost-empty threshold
AF_thr  in  ADDR_WIDTH+1  almost-full threshold
Fifo_Data_out  out  DATA_WIDTH  read data, registered
valid_out  out  1  Fifo_Data_out carries a freshly popped word
Fifo_Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
Fifo_Empty  out  1  count == 0
Fifo_Full  out  1  count == DEPTH
Almost_Empty  out  1  count <= AE_thr
Almost_Full  out  1  count >= AF_thr
Pausa  out  1  producer stall, equal to Almost_Full
Error_Fifo  out  1  one-cycle pulse on any rejected request

Behaviour:
- One clock (clk); reset_L is synchronous, active-low. It is sampled only on posedge clk and overrides all other inputs.
- Reset values:
  - wr_ptr, rd_ptr, Fifo_Count, Fifo_Data_out, valid_out, Error_Fifo, Fifo_Full, Almost_Full, Pausa = 0.
  - Fifo_Empty = 1; Almost_Empty = 1.
- Reset mid-operation discards all contents. Entries are not cleared in RAM but can never be read back.
- Push acceptance: push_ok = push && !Fifo_Full. On push_ok, RAM[wr_ptr] <= Fifo_Data_in and wr_ptr increments, wrapping modulo DEPTH.
- Pop acceptance: pop_ok = pop && !Fifo_Empty. On pop_ok, rd_ptr increments, wrapping modulo DEPTH.
- No fall-through: a push into an empty FIFO is not poppable in the same cycle.
- A push while Fifo_Full is rejected even if pop is also asserted; that pop is still accepted.
- Count update: next_count = count + push_ok - pop_ok, computed ADDR_WIDTH+1 bits wide. Both accepted -> count unchanged.
- Flags are registered and derived from next_count and the current AE_thr/AF_thr. All flags and Fifo_Count therefore change in the same cycle as the state change.
- A threshold change with no traffic takes effect one cycle later.
- Read latency is 1 cycle: pop_ok at edge N gives Fifo_Data_out = popped word and valid_out = 1 after edge N+1. Otherwise valid_out = 0 and Fifo_Data_out holds its last value.
- Error_Fifo = 1 for exactly one cycle after any edge with (push && Fifo_Full) or (pop && Fifo_Empty). It is not sticky, and a rejected request has no other effect.
- Word order is strictly preserved across pointer wrap-around.
- Thresholds outside 0..DEPTH are legal; the comparisons are simply unsigned.

Decomposition:
- Shared package fifo_pkg:
  - default DATA_WIDTH and ADDR_WIDTH;
  - a DEPTH function/constant;
  - default AE/AF threshold constants (1 and DEPTH-1) for integrators.
- One sub-module: dual_port_memory, with synchronous write and registered read at rd_ptr enabled by pop_ok.
- Pointer, count, flag and error logic stay in fifo_param.

Test Plan:
Defaults throughout: DATA_WIDTH=6, ADDR_WIDTH=2, AE_thr=1, AF_thr=3.
1. Reset for 2 cycles, then release -> Empty=1, Almost_Empty=1, Count=0, all other outputs 0.
2. Push 0x05, 0x0A, 0x15, 0x2A on 4 consecutive edges -> Count 1,2,3,4. Almost_Empty falls at count 2. Almost_Full and Pausa rise at count 3. Full at count 4. A 5th push -> Error_Fifo pulses 1 cycle, Count stays 4.
3. From full, pop 4 times -> valid_out=1 with Fifo_Data_out 0x05, 0x0A, 0x15, 0x2A, one cycle after each pop. Empty=1 after the last pop. An extra pop -> Error_Fifo pulse, valid_out=0, data holds 0x2A.
4. Stream 10 words 0x00..0x09 with pop trailing push by 2 cycles -> all 10 words read in order across pointer wrap. Count never exceeds 3, no Error_Fifo.
5. Simultaneous push+pop:
   - at count 2 -> count stays 2 and data order is intact;
   - at empty -> push accepted (count 1), Error_Fifo pulse;
   - at full -> pop accepted, push rejected, count 3, Error_Fifo pulse.
6. At count 3, assert reset_L=0 for 1 cycle -> next cycle Empty=1 and Count=0. A following pop gives Error_Fifo and valid_out=0; old data never appears.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and depth helper for the parametrised lane FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH = 2;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Suggested power-on thresholds for integrators driving AE_thr/AF_thr.
    localparam int DEF_AE_THR = 1;
    localparam int DEF_AF_THR = fifo_depth(DEF_ADDR_WIDTH) - 1;

endpackage
`default_nettype wire

// File: rtl/dual_port_memory.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_memory
// Description : Storage array with synchronous write and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_memory #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  i_reset_L,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Array carries no reset; stale words are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset_L) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Parametrised synchronous FIFO controller with occupancy count,
//               programmable almost-empty/almost-full flags and error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic [ADDR_WIDTH:0]   AE_thr,
    input  logic [ADDR_WIDTH:0]   AF_thr,
    output logic [DATA_WIDTH-1:0] Fifo_Data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   Fifo_Count,
    output logic                  Fifo_Empty,
    output logic                  Fifo_Full,
    output logic                  Almost_Empty,
    output logic                  Almost_Full,
    output logic                  Pausa,
    output logic                  Error_Fifo
);

    localparam int                c_DEPTH    = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_FULL_CNT = c_DEPTH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_valid;
    logic                  r_error;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [ADDR_WIDTH:0]   w_next_count;

    assign w_push_ok    = push && !r_full;
    assign w_pop_ok     = pop  && !r_empty;
    assign w_next_count = r_count + {{ADDR_WIDTH{1'b0}}, w_push_ok}
                                  - {{ADDR_WIDTH{1'b0}}, w_pop_ok};

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_valid        <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Flags look ahead at next_count so they move with the count itself.
            r_count        <= w_next_count;
            r_empty        <= (w_next_count == '0);
            r_full         <= (w_next_count == c_FULL_CNT);
            r_almost_empty <= (w_next_count <= AE_thr);
            r_almost_full  <= (w_next_count >= AF_thr);
            r_valid        <= w_pop_ok;
            r_error        <= (push && r_full) || (pop && r_empty);
        end
    end

    dual_port_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_reset_L (reset_L),
        .i_wr_en   (w_push_ok && reset_L),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (Fifo_Data_in),
        .i_rd_en   (w_pop_ok && reset_L),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (Fifo_Data_out)
    );

    assign valid_out    = r_valid;
    assign Fifo_Count   = r_count;
    assign Fifo_Empty   = r_empty;
    assign Fifo_Full    = r_full;
    assign Almost_Empty = r_almost_empty;
    assign Almost_Full  = r_almost_full;
    assign Pausa        = r_almost_full;
    assign Error_Fifo   = r_error;

endmodule
`default_nettype wire
